// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
// Memory-wait FSM encoding, register-index width, default latencies.
package pipe_ctrl_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = '0;

  localparam int MD_LATENCY_DEF  = 4;
  localparam int MEM_TIMEOUT_DEF = 64;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_e;

  // One bit per pipeline register, PC first.
  typedef struct packed {
    logic pc;
    logic if_id;
    logic id_ex;
    logic ex_mem;
    logic mem_wb;
  } stage_vec_t;

endpackage

// File: rtl/md_busy_counter.sv
// MDU busy counter: loads LATENCY on start, counts down to zero.
// Ports: clk, rst (async high), load; busy = count nonzero (registered).
module md_busy_counter #(
  parameter int LATENCY = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic busy
);

  localparam logic [3:0] LAT = 4'(LATENCY);

  logic [3:0] cnt;

  // Load wins over expiry in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LAT;
    end else if (cnt != '0) begin
      cnt <= cnt - 4'd1;
    end
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline (PC, IF/ID..MEM/WB).
// Inputs: ID operands, EX load/branch/mdStart, MEM dm handshake.
// Outputs: per-register en/flush, md_busy, sticky mem_err.
// Optional HAZARD_STATS_EN adds stat_mem_stall/stat_load_use/stat_flush.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MD_LATENCY  = MD_LATENCY_DEF,
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] ID_rs,
  input  logic [REG_W-1:0] ID_rt,
  input  logic             ID_usesRs,
  input  logic             ID_usesRt,
  input  logic             ID_usesMd,
  input  logic             EX_MemRead,
  input  logic [REG_W-1:0] EX_writeReg,
  input  logic             EX_branchTaken,
  input  logic             EX_mdStart,
  input  logic             MEM_dmReq,
  input  logic             MEM_dmReady,
  output logic             PC_en,
  output logic             IF_ID_en,
  output logic             ID_EX_en,
  output logic             EX_MEM_en,
  output logic             MEM_WB_en,
  output logic             IF_ID_flush,
  output logic             ID_EX_flush,
  output logic             EX_MEM_flush,
  output logic             MEM_WB_flush,
`ifdef HAZARD_STATS_EN
  output logic [31:0]      stat_mem_stall,
  output logic [31:0]      stat_load_use,
  output logic [31:0]      stat_flush,
`endif
  output logic             md_busy,
  output logic             mem_err
);

  localparam logic [7:0] TO_MAX = 8'(MEM_TIMEOUT - 1);

  mem_state_e state, state_n;
  logic [7:0] wait_cnt, wait_n;
  logic       err_n;

  logic timeout, mem_stall;
  logic load_use, md_hazard;
  logic c_mem, c_br, c_haz;

  stage_vec_t en, fl;

  assign timeout = (state == ST_WAIT) && !MEM_dmReady
                   && (wait_cnt == TO_MAX);

  assign mem_stall =
    ((state == ST_IDLE) && MEM_dmReq && !MEM_dmReady) ||
    ((state == ST_WAIT) && !MEM_dmReady && !timeout);

  assign load_use = EX_MemRead && (EX_writeReg != REG_ZERO) &&
    ((ID_usesRs && (ID_rs == EX_writeReg)) ||
     (ID_usesRt && (ID_rt == EX_writeReg)));

  assign md_hazard = ID_usesMd && md_busy;

  // Mutually exclusive priority terms.
  assign c_mem = !rst && mem_stall;
  assign c_br  = !rst && !mem_stall && EX_branchTaken;
  assign c_haz = !rst && !mem_stall && !EX_branchTaken
                 && (load_use || md_hazard);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      state    <= state_n;
      wait_cnt <= wait_n;
      mem_err  <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    wait_n  = wait_cnt;
    err_n   = mem_err;
    unique case (state)
      ST_IDLE: begin
        if (MEM_dmReq && !MEM_dmReady) begin
          state_n = ST_WAIT;
          wait_n  = '0;
        end
      end
      ST_WAIT: begin
        if (MEM_dmReady) begin
          state_n = ST_IDLE;
        end else if (timeout) begin
          state_n = ST_IDLE;
          err_n   = 1'b1;
        end else begin
          wait_n = wait_cnt + 8'd1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  md_busy_counter #(
    .LATENCY(MD_LATENCY)
  ) u_md (
    .clk (clk),
    .rst (rst),
    .load(EX_mdStart && !mem_stall),
    .busy(md_busy)
  );

  always_comb begin
    en = '1;
    fl = '0;
    unique case (1'b1)
      rst: begin
        en = '0;
        fl = '1;
      end
      // MEM/WB takes a bubble so WB never repeats a write.
      c_mem: begin
        en        = '0;
        en.mem_wb = 1'b1;
        fl.mem_wb = 1'b1;
      end
      c_br: begin
        fl.if_id = 1'b1;
        fl.id_ex = 1'b1;
      end
      c_haz: begin
        en.pc    = 1'b0;
        en.if_id = 1'b0;
        fl.id_ex = 1'b1;
      end
      default: ;
    endcase
  end

  assign PC_en        = en.pc;
  assign IF_ID_en     = en.if_id;
  assign ID_EX_en     = en.id_ex;
  assign EX_MEM_en    = en.ex_mem;
  assign MEM_WB_en    = en.mem_wb;
  assign IF_ID_flush  = fl.if_id;
  assign ID_EX_flush  = fl.id_ex;
  assign EX_MEM_flush = fl.ex_mem;
  assign MEM_WB_flush = fl.mem_wb;

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_mem_stall <= '0;
      stat_load_use  <= '0;
      stat_flush     <= '0;
    end else begin
      if (c_mem && (stat_mem_stall != '1))
        stat_mem_stall <= stat_mem_stall + 32'd1;
      if (c_haz && load_use && (stat_load_use != '1))
        stat_load_use <= stat_load_use + 32'd1;
      if (c_br && (stat_flush != '1))
        stat_flush <= stat_flush + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl (MD_LATENCY=4, MEM_TIMEOUT=64).
// Table of combinational vectors plus multi-cycle sequences.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] ID_rs, ID_rt, EX_writeReg;
  logic ID_usesRs, ID_usesRt, ID_usesMd;
  logic EX_MemRead, EX_branchTaken, EX_mdStart;
  logic MEM_dmReq, MEM_dmReady;
  logic PC_en, IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en;
  logic IF_ID_flush, ID_EX_flush, EX_MEM_flush, MEM_WB_flush;
  logic md_busy, mem_err;
`ifdef HAZARD_STATS_EN
  logic [31:0] stat_mem_stall, stat_load_use, stat_flush;
`endif

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MD_LATENCY(4), .MEM_TIMEOUT(64)) dut (
    .clk(clk), .rst(rst),
    .ID_rs(ID_rs), .ID_rt(ID_rt),
    .ID_usesRs(ID_usesRs), .ID_usesRt(ID_usesRt),
    .ID_usesMd(ID_usesMd),
    .EX_MemRead(EX_MemRead), .EX_writeReg(EX_writeReg),
    .EX_branchTaken(EX_branchTaken), .EX_mdStart(EX_mdStart),
    .MEM_dmReq(MEM_dmReq), .MEM_dmReady(MEM_dmReady),
    .PC_en(PC_en), .IF_ID_en(IF_ID_en), .ID_EX_en(ID_EX_en),
    .EX_MEM_en(EX_MEM_en), .MEM_WB_en(MEM_WB_en),
    .IF_ID_flush(IF_ID_flush), .ID_EX_flush(ID_EX_flush),
    .EX_MEM_flush(EX_MEM_flush), .MEM_WB_flush(MEM_WB_flush),
`ifdef HAZARD_STATS_EN
    .stat_mem_stall(stat_mem_stall),
    .stat_load_use(stat_load_use),
    .stat_flush(stat_flush),
`endif
    .md_busy(md_busy), .mem_err(mem_err)
  );

  // {PC,IF_ID,ID_EX,EX_MEM,MEM_WB en ; IF_ID,ID_EX,EX_MEM,MEM_WB flush}
  logic [8:0] outv;
  assign outv = {PC_en, IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en,
                 IF_ID_flush, ID_EX_flush, EX_MEM_flush, MEM_WB_flush};

  localparam logic [8:0] NORM  = 9'b11111_0000;
  localparam logic [8:0] HAZ   = 9'b00111_0100;
  localparam logic [8:0] BR    = 9'b11111_1100;
  localparam logic [8:0] STALL = 9'b00001_0001;
  localparam logic [8:0] RST   = 9'b00000_1111;

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  typedef struct {
    string      nm;
    logic [4:0] rs, rt;
    logic       urs, urt, umd, mrd;
    logic [4:0] wr;
    logic       br, mds, req, rdy;
    logic [8:0] exp;
  } vec_t;

  vec_t tv[12];

  task automatic idle();
    ID_rs = 0; ID_rt = 0; EX_writeReg = 0;
    ID_usesRs = 0; ID_usesRt = 0; ID_usesMd = 0;
    EX_MemRead = 0; EX_branchTaken = 0; EX_mdStart = 0;
    MEM_dmReq = 0; MEM_dmReady = 0;
  endtask

  task automatic apply(input vec_t v);
    ID_rs = v.rs; ID_rt = v.rt;
    ID_usesRs = v.urs; ID_usesRt = v.urt; ID_usesMd = v.umd;
    EX_MemRead = v.mrd; EX_writeReg = v.wr;
    EX_branchTaken = v.br; EX_mdStart = v.mds;
    MEM_dmReq = v.req; MEM_dmReady = v.rdy;
  endtask

  int stalls, held, busy;

  initial begin
    tv[0]  = '{"idle",      0, 0, 0,0,0,0,  0, 0,0,0,0, NORM};
    tv[1]  = '{"lu_rs",     8, 3, 1,1,0,1,  8, 0,0,0,0, HAZ};
    tv[2]  = '{"lu_zero",   0, 0, 1,1,0,1,  0, 0,0,0,0, NORM};
    tv[3]  = '{"lu_rt",     2, 9, 1,1,0,1,  9, 0,0,0,0, HAZ};
    tv[4]  = '{"lu_nouse",  8, 3, 0,1,0,1,  8, 0,0,0,0, NORM};
    tv[5]  = '{"lu_noload", 8, 3, 1,1,0,0,  8, 0,0,0,0, NORM};
    tv[6]  = '{"br_lu",     8, 3, 1,1,0,1,  8, 1,0,0,0, BR};
    tv[7]  = '{"mem_wait",  0, 0, 0,0,0,0,  0, 0,0,1,0, STALL};
    tv[8]  = '{"mem_zero",  0, 0, 0,0,0,0,  0, 0,0,1,1, NORM};
    tv[9]  = '{"mem_br_lu", 8, 3, 1,1,0,1,  8, 1,0,1,0, STALL};
    tv[10] = '{"md_idle",   0, 0, 0,0,1,0,  0, 0,0,0,0, NORM};
    tv[11] = '{"br_only",   0, 0, 0,0,0,0,  0, 1,0,0,0, BR};

    idle();
    #2;
    chk("rst_out", 32'(outv), 32'(RST));
    chk("rst_busy", 32'(md_busy), 0);
    chk("rst_err", 32'(mem_err), 0);
    @(negedge clk);
    rst = 1'b0;

    // Combinational table; inputs idle again before the edge.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      apply(tv[i]);
      #1;
      chk(tv[i].nm, 32'(outv), 32'(tv[i].exp));
      #1 idle();
    end

    // Load-use costs one bubble, then the EX bubble clears it.
    @(negedge clk);
    apply(tv[1]);
    #1 chk("lu_seq1", 32'(outv), 32'(HAZ));
    @(negedge clk);
    EX_MemRead = 0; EX_writeReg = 0;
    #1 chk("lu_seq2", 32'(outv), 32'(NORM));

    // Three wait cycles then ready.
    @(negedge clk);
    idle();
    MEM_dmReq = 1;
    stalls = 0;
    for (int i = 0; i < 4; i++) begin
      MEM_dmReady = (i == 3);
      #1;
      if (outv == STALL) stalls++;
      if (i == 3) chk("mem_release", 32'(outv), 32'(NORM));
      @(negedge clk);
    end
    idle();
    chk("mem_stalls3", stalls, 3);
    #1 chk("mem_err_ok", 32'(mem_err), 0);

    // MDU start, then mflo held until the counter drains.
    @(negedge clk);
    EX_mdStart = 1;
    #1 chk("md_start", 32'(md_busy), 0);
    @(negedge clk);
    EX_mdStart = 0; ID_usesMd = 1;
    held = 0; busy = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (md_busy) busy++;
      if (!PC_en) held++;
      if (PC_en) break;
      @(negedge clk);
    end
    chk("md_held", held, 4);
    chk("md_busy_cyc", busy, 4);
    chk("md_adv", 32'(outv), 32'(NORM));
    @(negedge clk);
    idle();

    // mdStart during a memory stall must not load.
    MEM_dmReq = 1; EX_mdStart = 1;
    #1 chk("mds_stall", 32'(outv), 32'(STALL));
    @(negedge clk);
    MEM_dmReady = 1; EX_mdStart = 0;
    #1 chk("mds_noload", 32'(md_busy), 0);
    @(negedge clk);
    idle();

    // Branch during stall: ignored, then one flush on release.
    MEM_dmReq = 1; EX_branchTaken = 1;
    #1 chk("brst1", 32'(outv), 32'(STALL));
    @(negedge clk);
    #1 chk("brst2", 32'(outv), 32'(STALL));
    @(negedge clk);
    MEM_dmReady = 1;
    #1 chk("brst_rel", 32'(outv), 32'(BR));
    @(negedge clk);
    idle();
    #1 chk("brst_after", 32'(outv), 32'(NORM));

    // Timeout: 64 stall cycles, resume, sticky mem_err.
    @(negedge clk);
    MEM_dmReq = 1;
    stalls = 0;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (outv != STALL) break;
      stalls++;
      @(negedge clk);
    end
    chk("to_stalls", stalls, 64);
    chk("to_resume", 32'(outv), 32'(NORM));
    chk("to_err_pre", 32'(mem_err), 0);
    @(negedge clk);
    idle();
    #1 chk("to_err", 32'(mem_err), 1);
    @(negedge clk);
    @(negedge clk);
    #1 chk("to_sticky", 32'(mem_err), 1);

    // Reset in the middle of WAIT.
    @(negedge clk);
    MEM_dmReq = 1;
    @(negedge clk);
    @(negedge clk);
    #1 chk("wait_pre", 32'(outv), 32'(STALL));
    rst = 1;
    #1;
    chk("rst_mid_out", 32'(outv), 32'(RST));
    chk("rst_mid_err", 32'(mem_err), 0);
    @(negedge clk);
    idle();
    rst = 0;
    #1 chk("rst_mid_idle", 32'(outv), 32'(NORM));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage MIPS pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB registers plus PC).
- Detects load-use hazards, taken-branch squashes, multiply/divide unit (MDU) busy interlock and data-memory wait states.
- Emits one enable and one synchronous-flush per pipeline register.
- Holds the only sequential control state of the pipeline: the memory-wait FSM, the MDU busy counter and the wait timeout.

Parameters:
- MD_LATENCY, 4, cycles the MDU stays busy after a start (1..15).
- MEM_TIMEOUT, 64, max consecutive memory wait cycles before mem_err (2..255).

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous, active-high reset
- ID_rs  in  5  rs field of instruction in ID
- ID_rt  in  5  rt field of instruction in ID
- ID_usesRs  in  1  ID instruction reads rs
- ID_usesRt  in  1  ID instruction reads rt
- ID_usesMd  in  1  ID instruction reads or starts MDU (mult/div/mfhi/mflo)
- EX_MemRead  in  1  EX instruction is a load
- EX_writeReg  in  5  destination register of EX instruction
- EX_branchTaken  in  1  branch/jump resolved taken in EX
- EX_mdStart  in  1  EX instruction starts the MDU
- MEM_dmReq  in  1  MEM instruction accesses data memory
- MEM_dmReady  in  1  data memory completes access this cycle
- PC_en  out  1  PC load enable
- IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en  out  1 each  register enables
- IF_ID_flush, ID_EX_flush, EX_MEM_flush, MEM_WB_flush  out  1 each  load bubble (all fields 0) on next edge
- md_busy  out  1  MDU counter nonzero
- mem_err  out  1  sticky memory timeout flag

Behaviour:
- Reset (async, rst=1): FSM=IDLE, md_cnt=0, wait_cnt=0, mem_err=0.
  - While rst=1: all *_en=0, all *_flush=1, md_busy=0.
- Memory FSM, states IDLE / WAIT:
  - IDLE->WAIT when MEM_dmReq & !MEM_dmReady.
  - WAIT->IDLE when MEM_dmReady.
  - WAIT->IDLE when wait_cnt reaches MEM_TIMEOUT-1; this sets mem_err=1 (sticky until rst).
  - wait_cnt clears on entry to WAIT and increments each WAIT cycle.
- mem_stall = (IDLE & MEM_dmReq & !MEM_dmReady) | (WAIT & !MEM_dmReady & !timeout).
  - Zero-wait access (ready in the same cycle as the request) causes no stall.
- load_use = EX_MemRead & EX_writeReg!=0 & ((ID_usesRs & ID_rs==EX_writeReg) | (ID_usesRt & ID_rt==EX_writeReg)).
- md_hazard = ID_usesMd & md_busy.
- MDU counter:
  - Loads MD_LATENCY when EX_mdStart & !mem_stall; otherwise decrements if nonzero.
  - md_busy = (md_cnt != 0), driven from the register, no combinational path.
  - A load and expiry in the same cycle gives the load priority.
- Priority, highest first (outputs combinational from state + inputs):
  1. mem_stall:
     - PC_en, IF_ID_en, ID_EX_en, EX_MEM_en = 0.
     - MEM_WB_en=1 with MEM_WB_flush=1 (bubble, so WB never writes twice).
     - Branch and hazards are ignored this cycle and re-evaluated when the stall releases, since EX holds its instruction.
  2. EX_branchTaken:
     - All en=1; IF_ID_flush=1, ID_EX_flush=1.
     - load_use and md_hazard are suppressed because the ID instruction is squashed.
  3. load_use | md_hazard:
     - PC_en=0, IF_ID_en=0; ID_EX_flush=1.
     - EX_MEM and MEM_WB advance.
  4. Otherwise: all en=1, all flush=0.
- EX_MEM_flush is 0 except during rst.
- Any flush has priority over hold inside the register; a flushed register must also have en=1.
- Latency:
  - Load-use costs exactly 1 bubble.
  - MDU hazard stalls until the cycle md_cnt reads 0.
  - A memory wait of N cycles freezes for N cycles.

Optional Feature:
- Macro HAZARD_STATS_EN.
- When defined, adds three 32-bit saturating counters, cleared on rst, readable as outputs:
  - stat_mem_stall: cycles with mem_stall.
  - stat_load_use: cycles with case 3 caused by load_use.
  - stat_flush: taken branches.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package pipe_ctrl_pkg:
  - FSM state encoding (IDLE=0, WAIT=1).
  - Register-index width 5 and the $zero index constant.
  - Default MD_LATENCY and MEM_TIMEOUT.
- One sub-module, md_busy_counter (load/decrement/busy), reused by a future divider-only unit.

Test Plan:
- lw $8 in EX, ID add uses rs=8 -> exactly 1 cycle with PC_en=0, IF_ID_en=0, ID_EX_flush=1; none when EX_writeReg=0.
- MEM_dmReq=1 with MEM_dmReady low for 3 cycles -> 3 cycles with front stages held and MEM_WB_flush=1; release on the ready cycle; mem_err stays 0.
- EX_branchTaken=1 with a simultaneous load_use -> IF_ID_flush=1, ID_EX_flush=1, PC_en=1, no stall.
- EX_mdStart, then mflo in ID next cycle (MD_LATENCY=4) -> md_busy for 4 cycles, ID held 4 cycles, advance on the 5th.
- MEM_dmReady held low 64 cycles -> mem_err rises after cycle 64 and the pipeline resumes; rst mid-WAIT -> immediate IDLE, mem_err=0, all flush=1.
- Branch taken during mem_stall -> ignored until the stall releases, then flushes once.
